// File: rtl/gate_resp_checker.sv
// ---------------------------------------------------------------------------
// gate_resp_checker
//
// Exhaustive stimulus/response checker for a small combinational gate. A run
// steps vec through every input pattern 0 .. 2^N_IN-1. Each pattern is held
// for SETTLE cycles and then sampled for one cycle. The sampled gate output y
// is compared with the expected truth-table bit TRUTH[vec]. At the end of the
// run the block reports a pass/fail verdict, the number of mismatches and the
// first pattern that mismatched.
//
// Parameters
//   N_IN    number of gate inputs (1..4); vec MSB drives gate input a
//   TRUTH   expected y per pattern, bit i = y for vec == i
//   SETTLE  cycles a pattern is held before it is sampled (>= 1)
//
// Ports
//   clk         in   single clock, rising edge
//   rst         in   synchronous reset, active-high; aborts a run silently
//   start       in   begin a run; honoured only while idle
//   vec         out  pattern applied to the gate inputs
//   y           in   gate output under test, looked at only while sampling
//   busy        out  high while a run is in progress
//   done        out  one-cycle pulse at the end of a run
//   pass        out  last run had zero mismatches (valid from done onward)
//   err_cnt     out  mismatch count of the last run (0 .. 2^N_IN)
//   fail_seen   out  at least one mismatch in the current/last run
//   first_fail  out  first mismatching pattern; 0 when fail_seen is 0
// ---------------------------------------------------------------------------
module gate_resp_checker #(
    parameter int                 N_IN   = 2,
    parameter logic [2**N_IN-1:0] TRUTH  = 4'b1110,
    parameter int                 SETTLE = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [N_IN-1:0] vec,
    input  logic            y,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_cnt,
    output logic            fail_seen,
    output logic [N_IN-1:0] first_fail
);

    localparam int              ERR_W    = N_IN + 1;
    localparam int              CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
    localparam logic [N_IN-1:0]  VEC_LAST = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t            state_q,      state_d;
    logic [CNT_W-1:0]  cnt_q,        cnt_d;
    logic [N_IN-1:0]   vec_q,        vec_d;
    logic              busy_q,       busy_d;
    logic              done_q,       done_d;
    logic              pass_q,       pass_d;
    logic [ERR_W-1:0]  err_cnt_q,    err_cnt_d;
    logic              fail_seen_q,  fail_seen_d;
    logic [N_IN-1:0]   first_fail_q, first_fail_d;
    logic              mismatch;

    // Only meaningful in S_SAMPLE; the FSM ignores it everywhere else.
    assign mismatch = (y != TRUTH[vec_q]);

    always_comb begin
        // NOTE: every signal gets a hold/default value up front so no path
        // through the case statement can infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        vec_d        = vec_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        pass_d       = pass_q;
        err_cnt_d    = err_cnt_q;
        fail_seen_d  = fail_seen_q;
        first_fail_d = first_fail_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_SETTLE;
                    cnt_d        = '0;
                    vec_d        = '0;
                    busy_d       = 1'b1;
                    pass_d       = 1'b0;
                    err_cnt_d    = '0;
                    fail_seen_d  = 1'b0;
                    first_fail_d = '0;
                end
            end

            S_SETTLE: begin
                // Stop counting at the last settle cycle so the counter never
                // needs more than $clog2(SETTLE) bits.
                if (cnt_q == CNT_LAST) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_SAMPLE: begin
                if (mismatch) begin
                    err_cnt_d = err_cnt_q + ERR_W'(1);
                    if (!fail_seen_q) begin
                        fail_seen_d  = 1'b1;
                        first_fail_d = vec_q;
                    end
                end
                if (vec_q == VEC_LAST) begin
                    // Verdict is taken from the count that includes this
                    // final sample, so pass is already valid while done is high.
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_cnt_d == '0);
                end else begin
                    state_d = S_SETTLE;
                    vec_d   = vec_q + N_IN'(1);
                    cnt_d   = '0;
                end
            end

            S_DONE: begin
                // start is deliberately not looked at here.
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the values computed before this edge regardless of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            vec_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_cnt_q    <= '0;
            fail_seen_q  <= 1'b0;
            first_fail_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            vec_q        <= vec_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_cnt_q    <= err_cnt_d;
            fail_seen_q  <= fail_seen_d;
            first_fail_q <= first_fail_d;
        end
    end

    assign vec        = vec_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_cnt    = err_cnt_q;
    assign fail_seen  = fail_seen_q;
    assign first_fail = first_fail_q;

endmodule

// File: tb/tb_gate_resp_checker.sv
// ---------------------------------------------------------------------------
// tb_gate_resp_checker
//
// Bench for gate_resp_checker with default parameters (2-input OR truth
// table, SETTLE = 2). A small gate model produces y from vec. Each accepted
// start pushes the hand-computed result of that run, including the cycle in
// which done must appear, into a scoreboard queue. The monitor pops and
// compares the queue head whenever done is seen. A done that arrives with an
// empty queue is reported as an error.
// ---------------------------------------------------------------------------
module tb_gate_resp_checker;

    typedef enum int { G_OR, G_ZERO, G_AND, G_NOR } gate_t;

    typedef struct {
        int         done_cyc;
        logic       pass;
        logic [2:0] err_cnt;
        logic       fail_seen;
        logic [1:0] first_fail;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] vec;
    logic       y;
    logic       busy, done, pass, fail_seen;
    logic [2:0] err_cnt;
    logic [1:0] first_fail;

    gate_t      mode = G_OR;
    int         cyc = 0;
    int         n_total = 0;
    int         n_pass = 0;
    exp_t       sb_q[$];
    exp_t       mon_e;

    gate_resp_checker #(
        .N_IN   (2),
        .TRUTH  (4'b1110),
        .SETTLE (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .vec        (vec),
        .y          (y),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_cnt    (err_cnt),
        .fail_seen  (fail_seen),
        .first_fail (first_fail)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Gate under test: vec = {a, b}.
    always_comb begin
        y = 1'b0;
        case (mode)
            G_OR:    y = vec[1] | vec[0];
            G_ZERO:  y = 1'b0;
            G_AND:   y = vec[1] & vec[0];
            G_NOR:   y = ~(vec[1] | vec[0]);
            default: y = 1'b0;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare every done pulse against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && done) begin
            check("done_expected", (sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                check("done_cycle", cyc, mon_e.done_cyc);
                check("busy_at_done", busy, 0);
                check("pass", pass, mon_e.pass);
                check("err_cnt", err_cnt, mon_e.err_cnt);
                check("fail_seen", fail_seen, mon_e.fail_seen);
                check("first_fail", first_fail, mon_e.first_fail);
            end
        end
    end

    // Called at a negedge: raise start for one edge, then record the result
    // this run must produce. Default timing gives 4 * (2 + 1) = 12 cycles of
    // busy, so done is visible 12 edges after the edge that accepted start.
    task automatic start_run(input logic p, input int ec, input logic fs, input int ff);
        exp_t e;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e.done_cyc   = cyc + 12;
        e.pass       = p;
        e.err_cnt    = 3'(ec);
        e.fail_seen  = fs;
        e.first_fail = 2'(ff);
        sb_q.push_back(e);
    endtask

    // Step negedges until done is high, bounded.
    task automatic wait_done(input string name);
        bit seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        check(name, seen, 1);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_vec", vec, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_fail_seen", fail_seen, 0);
        check("rst_first_fail", first_fail, 0);
        check("rst_pass", pass, 0);
        rst = 1'b0;
        idle_cycles(2);

        // ---------------- 1: OR gate, all match, vec sequence ----------------
        mode = G_OR;
        start_run(1'b1, 0, 1'b0, 0);
        // Vector k/3 is held for 3 cycles (2 settle + 1 sample).
        for (int k = 0; k < 12; k++) begin
            check("t1_vec_step", vec, k / 3);
            check("t1_busy", busy, 1);
            @(negedge clk);
        end
        check("t1_done_now", done, 1);
        idle_cycles(3);
        check("t1_vec_hold_idle", vec, 3);
        check("t1_pass_hold", pass, 1);
        check("t1_sb_empty", sb_q.size(), 0);

        // ---------------- 2: y tied low ----------------
        mode = G_ZERO;
        start_run(1'b0, 3, 1'b1, 1);
        wait_done("t2_done_seen");
        idle_cycles(2);

        // ---------------- 3: AND gate against OR table ----------------
        mode = G_AND;
        start_run(1'b0, 2, 1'b1, 1);
        wait_done("t3_done_seen");
        idle_cycles(2);
        check("t3_results_hold", err_cnt, 2);

        // ---------------- 4: extra starts are ignored ----------------
        mode = G_OR;
        start_run(1'b1, 0, 1'b0, 0);
        idle_cycles(4);
        start = 1'b1;                  // sampled 5 edges after acceptance
        @(negedge clk);
        start = 1'b0;
        wait_done("t4_done_seen");
        start = 1'b1;                  // sampled on the edge leaving DONE
        @(negedge clk);
        start = 1'b0;
        check("t4_no_restart_busy", busy, 0);
        idle_cycles(20);
        check("t4_still_idle", busy, 0);
        check("t4_sb_empty", sb_q.size(), 0);

        // ---------------- 5: reset mid-run ----------------
        mode = G_ZERO;
        start_run(1'b0, 3, 1'b1, 1);
        idle_cycles(5);
        rst = 1'b1;                    // sampled 6 edges after acceptance
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();                 // aborted run must never report
        check("t5_busy", busy, 0);
        check("t5_vec", vec, 0);
        check("t5_err_cnt", err_cnt, 0);
        check("t5_done", done, 0);
        check("t5_fail_seen", fail_seen, 0);
        idle_cycles(20);               // monitor flags any stray done here
        check("t5_idle_after", busy, 0);
        mode = G_OR;
        start_run(1'b1, 0, 1'b0, 0);
        wait_done("t5_rerun_done_seen");

        // ---------------- 6: back-to-back runs ----------------
        idle_cycles(2);
        mode = G_OR;
        start_run(1'b1, 0, 1'b0, 0);
        wait_done("t6_run1_done_seen");
        @(negedge clk);                // first IDLE cycle after DONE
        mode = G_NOR;
        start_run(1'b0, 4, 1'b1, 0);
        check("t6_cleared_err", err_cnt, 0);
        check("t6_cleared_pass", pass, 0);
        wait_done("t6_run2_done_seen");

        idle_cycles(5);
        check("final_sb_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
